cu_data_write_engine_control: RTL and testbench

CU_DATA_WRITE_ENGINE_CONTROL -- requirements
Module: cu_data_write_engine_control

---
 rtl/cu_data_write_engine_control_if.sv | 118 +++++++++++
 rtl/cu_data_write_engine_control.sv | 144 ++++++++++++++
 tb/tb_cu_data_write_engine_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_data_write_engine_control_if.sv
// Shared CAPI-style types for the data write engine and its grouped port bundle.
// The slave modport is the engine's view; master is the surrounding arbiter/producer view.
package cu_dwe_pkg;
    localparam int          ARRAY_SIZE_BITS       = 32;
    localparam logic [31:0] CACHELINE_ARRAY_NUM   = 32'd32;
    localparam logic [63:0] CACHELINE_SIZE        = 64'd128;
    localparam logic [7:0]  DATA_WRITE_CONTROL_ID = 8'h05;
    localparam logic [12:0] WRITE_NA              = 13'h0D00;

    typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE, CMD_WED} command_type_t;
    typedef enum logic [1:0] {STRUCT_INVALID, READ_DATA, WRITE_DATA, WED_DATA} array_struct_t;
    typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_t;

    typedef struct packed {
        logic [63:0] array_receive;
        logic [31:0] size_recive;
        logic [63:0] afu_config;
    } wed_t;

    typedef struct packed {
        logic valid;
        wed_t wed;
    } WEDInterface;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        logic [7:0]    cu_id;
        command_type_t cmd_type;
        array_struct_t array_struct;
        logic [31:0]   real_size;
        logic [7:0]    cacheline_offest;
        logic [63:0]   address_offest;
        trans_order_t  abt;
    } CommandTagLine;

    typedef struct packed {
        logic          valid;
        logic [12:0]   command;
        logic [63:0]   address;
        logic [11:0]   size;
        trans_order_t  abt;
        CommandTagLine cmd;
    } CommandBufferLine;

    typedef struct packed {
        logic          valid;
        logic [3:0]    response;
        CommandTagLine cmd;
    } ResponseBufferLine;

    typedef struct packed {
        logic empty;
        logic alfull;
        logic full;
    } BufferStatus;

    // Transfer size in bytes: a full line, or 4-byte elements rounded up to a power of two.
    function automatic logic [11:0] cmd_size_calculate(input logic [31:0] remaining);
        logic [31:0] bytes;
        logic [31:0] size;
        bytes = remaining << 2;
        size  = 32'd1;
        if (remaining >= CACHELINE_ARRAY_NUM) begin
            size = CACHELINE_SIZE[31:0];
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (size < bytes) size = size << 1;
            end
        end
        return size[11:0];
    endfunction

    function automatic trans_order_t map_CABT(input logic [2:0] cfg);
        case (cfg)
            3'd1:    return ABORT;
            3'd2:    return PAGE;
            3'd3:    return PREF;
            3'd4:    return SPEC;
            default: return STRICT;
        endcase
    endfunction
endpackage

interface cu_data_write_engine_control_if;
    import cu_dwe_pkg::*;

    logic                          enabled_in;
    WEDInterface                   wed_request_in;
    ReadWriteDataLine              write_data_0_in;
    ReadWriteDataLine              write_data_1_in;
    ResponseBufferLine             write_response_in;
    BufferStatus                   write_command_buffer_status;
    BufferStatus                   write_data_buffer_status;
    CommandBufferLine              write_command_out;
    ReadWriteDataLine              write_data_0_out;
    ReadWriteDataLine              write_data_1_out;
    logic                          write_data_ready_out;
    logic [ARRAY_SIZE_BITS-1:0]    write_job_counter_done;
    logic                          write_job_done_out;

    modport slave (
        input  enabled_in, wed_request_in, write_data_0_in, write_data_1_in, write_response_in,
               write_command_buffer_status, write_data_buffer_status,
        output write_command_out, write_data_0_out, write_data_1_out, write_data_ready_out,
               write_job_counter_done, write_job_done_out
    );

    modport master (
        output enabled_in, wed_request_in, write_data_0_in, write_data_1_in, write_response_in,
               write_command_buffer_status, write_data_buffer_status,
        input  write_command_out, write_data_0_out, write_data_1_out, write_data_ready_out,
               write_job_counter_done, write_job_done_out
    );
endinterface

// File: rtl/cu_data_write_engine_control.sv
// Turns a WED job plus a stream of half-line data beats into WRITE_NA commands and counts acks.
// Latency: data beat in -> command out is 2 cycles (input register + command register).
// Backpressure: registered write_data_ready_out drops the cycle after either buffer reports alfull.
module cu_data_write_engine_control
    import cu_dwe_pkg::*;
(
    input logic                           clock,
    input logic                           rstn,
    cu_data_write_engine_control_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_WED, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic              enabled;
    logic [63:0]       base_q;
    logic [31:0]       size_q;
    trans_order_t      abt_q;
    logic [31:0]       remaining_q, remaining_n;
    logic [63:0]       offset_q, offset_n;
    logic [31:0]       counter_q, counter_n;
    ReadWriteDataLine  data0_q, data1_q;
    ReadWriteDataLine  data0_out_q, data0_out_n, data1_out_q, data1_out_n;
    CommandBufferLine  cmd_q, cmd_n;
    logic              ready_q, ready_n;
    logic              wed_take, issue, resp_hit;
    logic [31:0]       real_size;
    logic              unused_bits;

    assign wed_take  = enabled && (state == WAIT_WED) && bus.wed_request_in.valid;
    assign issue     = enabled && (state == ISSUE) && (remaining_q != 32'd0) && data0_q.valid;
    // Idle blocks stale acks from a job abandoned by reset or disable.
    assign resp_hit  = (state != IDLE) && bus.write_response_in.valid &&
                       (bus.write_response_in.cmd.cu_id == DATA_WRITE_CONTROL_ID);
    assign real_size = (remaining_q >= CACHELINE_ARRAY_NUM) ? CACHELINE_ARRAY_NUM : remaining_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (enabled) state_n = WAIT_WED;
            WAIT_WED: if (bus.wed_request_in.valid)
                          state_n = (bus.wed_request_in.wed.size_recive == 32'd0) ? DRAIN : ISSUE;
            ISSUE:    if (remaining_q == 32'd0) state_n = DRAIN;
            DRAIN:    if (counter_q == size_q) state_n = DONE;
            DONE:     state_n = DONE;
            default:  state_n = IDLE;
        endcase
        if (!enabled) state_n = IDLE;
    end

    always_comb begin
        remaining_n = remaining_q;
        offset_n    = offset_q;
        counter_n   = counter_q;
        cmd_n       = '0;
        data0_out_n = '0;
        data1_out_n = '0;

        if (wed_take) remaining_n = bus.wed_request_in.wed.size_recive;

        if (issue) begin
            remaining_n                 = remaining_q - real_size;
            offset_n                    = offset_q + CACHELINE_SIZE;
            cmd_n.valid                 = 1'b1;
            cmd_n.command               = WRITE_NA;
            cmd_n.address               = base_q + offset_q;
            cmd_n.size                  = cmd_size_calculate(remaining_q);
            cmd_n.abt                   = abt_q;
            cmd_n.cmd.cu_id             = DATA_WRITE_CONTROL_ID;
            cmd_n.cmd.cmd_type          = CMD_WRITE;
            cmd_n.cmd.array_struct      = WRITE_DATA;
            cmd_n.cmd.real_size         = real_size;
            cmd_n.cmd.cacheline_offest  = 8'd0;
            cmd_n.cmd.address_offest    = offset_q;
            cmd_n.cmd.abt               = abt_q;
            data0_out_n                 = data0_q;
            data1_out_n                 = data1_q;
        end

        if (resp_hit) counter_n = counter_q + bus.write_response_in.cmd.real_size;

        if (!enabled) begin
            remaining_n = '0;
            offset_n    = '0;
            counter_n   = '0;
        end

        // Uses the post-update remaining so ready falls the cycle the last element is committed.
        ready_n = (state_n == ISSUE) && (remaining_n != 32'd0) &&
                  !bus.write_command_buffer_status.alfull && !bus.write_data_buffer_status.alfull;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled     <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            abt_q       <= STRICT;
            remaining_q <= '0;
            offset_q    <= '0;
            counter_q   <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            data0_out_q <= '0;
            data1_out_q <= '0;
            cmd_q       <= '0;
            ready_q     <= 1'b0;
        end else begin
            enabled     <= bus.enabled_in;
            if (wed_take) begin
                base_q <= bus.wed_request_in.wed.array_receive;
                size_q <= bus.wed_request_in.wed.size_recive;
                abt_q  <= map_CABT(bus.wed_request_in.wed.afu_config[2:0]);
            end
            remaining_q <= remaining_n;
            offset_q    <= offset_n;
            counter_q   <= counter_n;
            data0_q     <= bus.write_data_0_in;
            data1_q     <= bus.write_data_1_in;
            data0_out_q <= data0_out_n;
            data1_out_q <= data1_out_n;
            cmd_q       <= cmd_n;
            ready_q     <= ready_n;
        end
    end

    assign bus.write_command_out      = cmd_q;
    assign bus.write_data_0_out       = data0_out_q;
    assign bus.write_data_1_out       = data1_out_q;
    assign bus.write_data_ready_out   = ready_q;
    assign bus.write_job_counter_done = counter_q;
    assign bus.write_job_done_out     = (state == DONE);

    assign unused_bits = ^{bus.wed_request_in.wed.afu_config[63:3], bus.write_response_in.response,
                           bus.write_response_in.cmd.cmd_type, bus.write_response_in.cmd.array_struct,
                           bus.write_response_in.cmd.cacheline_offest, bus.write_response_in.cmd.address_offest,
                           bus.write_response_in.cmd.abt,
                           bus.write_command_buffer_status.empty, bus.write_command_buffer_status.full,
                           bus.write_data_buffer_status.empty, bus.write_data_buffer_status.full};
endmodule

// File: tb/tb_cu_data_write_engine_control.sv
// Directed bench: a per-cycle vector table for a 40-element job, then hand sequences
// for empty job, alfull backpressure with coincident ack, and mid-job reset.
module tb_cu_data_write_engine_control;
    import cu_dwe_pkg::*;

    logic clock = 1'b0;
    logic rstn;
    always #5 clock = ~clock;

    cu_data_write_engine_control_if bus();

    cu_data_write_engine_control dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [7:0]  OTHER_ID = 8'h09;
    localparam logic [31:0] D1_MASK  = 32'hFFFF_0000;

    typedef struct {
        logic        en;
        logic        wv;
        logic        dv;
        logic [31:0] tag;
        logic        rv;
        logic [7:0]  rcu;
        logic [31:0] rrs;
        logic        e_rdy;
        logic        e_cv;
        logic [63:0] e_addr;
        logic [31:0] e_rs;
        logic [11:0] e_sz;
        logic [31:0] e_tag;
        logic [31:0] e_cnt;
        logic        e_done;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_wed(input logic [63:0] base, input logic [31:0] size);
        bus.wed_request_in.valid             = 1'b1;
        bus.wed_request_in.wed.array_receive = base;
        bus.wed_request_in.wed.size_recive   = size;
        bus.wed_request_in.wed.afu_config    = 64'h2;
    endtask

    task automatic drive_beat(input logic dv, input logic [31:0] tag);
        bus.write_data_0_in.valid = dv;
        bus.write_data_0_in.data  = {480'b0, tag};
        bus.write_data_1_in.valid = dv;
        bus.write_data_1_in.data  = {480'b0, tag ^ D1_MASK};
    endtask

    task automatic drive_resp(input logic rv, input logic [7:0] cu, input logic [31:0] rs);
        bus.write_response_in           = '0;
        bus.write_response_in.valid     = rv;
        bus.write_response_in.cmd.cu_id = cu;
        bus.write_response_in.cmd.real_size = rs;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (bus.write_data_ready_out !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(nm, {63'b0, bus.write_data_ready_out}, 64'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (bus.write_job_done_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {63'b0, bus.write_job_done_out}, 64'd1);
    endtask

    task automatic disable_job;
        bus.enabled_in = 1'b0;
        bus.wed_request_in = '0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        logic        cmd_seen;
        logic [31:0] e_d1;

        rstn = 1'b0;
        bus.enabled_in = 1'b0;
        bus.wed_request_in = '0;
        bus.write_data_0_in = '0;
        bus.write_data_1_in = '0;
        bus.write_response_in = '0;
        bus.write_command_buffer_status = '0;
        bus.write_data_buffer_status = '0;

        //            en    wv    dv    tag            rv    rcu                    rrs     rdy   cv    addr       rs      sz      etag           cnt     done
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b1, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hA0A0_0001, 1'b0, 8'h0,                  32'd0,  1'b1, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'hB0B0_0002, 1'b0, 8'h0,                  32'd0,  1'b1, 1'b1, 64'h1000,  32'd32, 12'd128, 32'hA0A0_0001, 32'd0,  1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b1, 64'h1080,  32'd8,  12'd32, 32'hB0B0_0002, 32'd0,  1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, DATA_WRITE_CONTROL_ID, 32'd32, 1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd32, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, OTHER_ID,              32'd32, 1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd32, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, DATA_WRITE_CONTROL_ID, 32'd8,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd40, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd40, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd40, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd40, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h0,                  32'd0,  1'b0, 1'b0, 64'h0,     32'd0,  12'd0,  32'h0,         32'd0,  1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_ready", {63'b0, bus.write_data_ready_out}, 64'd0);
        chk("rst_cmd_valid", {63'b0, bus.write_command_out.valid}, 64'd0);
        chk("rst_counter", {32'b0, bus.write_job_counter_done}, 64'd0);
        chk("rst_done", {63'b0, bus.write_job_done_out}, 64'd0);
        rstn = 1'b1;
        tick();

        // Main 40-element job, one row per cycle
        set_wed(64'h1000, 32'd40);
        for (int i = 0; i < 14; i++) begin
            bus.enabled_in = vecs[i].en;
            bus.wed_request_in.valid = vecs[i].wv;
            drive_beat(vecs[i].dv, vecs[i].tag);
            drive_resp(vecs[i].rv, vecs[i].rcu, vecs[i].rrs);
            tick();
            chk($sformatf("v%0d_ready", i), {63'b0, bus.write_data_ready_out}, {63'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d_cmd_valid", i), {63'b0, bus.write_command_out.valid}, {63'b0, vecs[i].e_cv});
            chk($sformatf("v%0d_addr", i), bus.write_command_out.address, vecs[i].e_addr);
            chk($sformatf("v%0d_real_size", i), {32'b0, bus.write_command_out.cmd.real_size}, {32'b0, vecs[i].e_rs});
            chk($sformatf("v%0d_size", i), {52'b0, bus.write_command_out.size}, {52'b0, vecs[i].e_sz});
            chk($sformatf("v%0d_data0", i), bus.write_data_0_out.data[63:0], {32'b0, vecs[i].e_tag});
            e_d1 = vecs[i].e_cv ? (vecs[i].e_tag ^ D1_MASK) : 32'h0;
            chk($sformatf("v%0d_data1", i), bus.write_data_1_out.data[63:0], {32'b0, e_d1});
            chk($sformatf("v%0d_counter", i), {32'b0, bus.write_job_counter_done}, {32'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d_done", i), {63'b0, bus.write_job_done_out}, {63'b0, vecs[i].e_done});
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d_command", i), {51'b0, bus.write_command_out.command}, {51'b0, WRITE_NA});
                chk($sformatf("v%0d_cu_id", i), {56'b0, bus.write_command_out.cmd.cu_id}, {56'b0, DATA_WRITE_CONTROL_ID});
                chk($sformatf("v%0d_abt", i), {61'b0, bus.write_command_out.abt}, 64'd2);
                chk($sformatf("v%0d_addr_off", i), bus.write_command_out.cmd.address_offest, vecs[i].e_addr - 64'h1000);
            end
        end
        drive_beat(1'b0, 32'h0);
        drive_resp(1'b0, 8'h0, 32'd0);

        // Empty job: straight to done with no command
        set_wed(64'h4000, 32'd0);
        bus.enabled_in = 1'b1;
        cmd_seen = 1'b0;
        for (int n = 0; n < 12 && bus.write_job_done_out !== 1'b1; n++) begin
            tick();
            cmd_seen = cmd_seen | bus.write_command_out.valid;
        end
        chk("empty_done", {63'b0, bus.write_job_done_out}, 64'd1);
        chk("empty_counter", {32'b0, bus.write_job_counter_done}, 64'd0);
        chk("empty_no_cmd", {63'b0, cmd_seen}, 64'd0);
        disable_job();

        // Backpressure, then a response coinciding with a command
        set_wed(64'h2000, 32'd96);
        bus.enabled_in = 1'b1;
        wait_ready("bp_ready_wait");
        drive_beat(1'b1, 32'h0000_00C1);
        tick();
        drive_beat(1'b0, 32'h0);
        tick();
        chk("bp_cmd0_addr", bus.write_command_out.address, 64'h2000);
        bus.write_command_buffer_status.alfull = 1'b1;
        tick();
        chk("bp_alfull_ready", {63'b0, bus.write_data_ready_out}, 64'd0);
        chk("bp_alfull_nocmd", {63'b0, bus.write_command_out.valid}, 64'd0);
        tick();
        chk("bp_alfull_ready2", {63'b0, bus.write_data_ready_out}, 64'd0);
        bus.write_command_buffer_status.alfull = 1'b0;
        tick();
        chk("bp_release_ready", {63'b0, bus.write_data_ready_out}, 64'd1);
        drive_beat(1'b1, 32'h0000_00C2);
        tick();
        drive_beat(1'b0, 32'h0);
        drive_resp(1'b1, DATA_WRITE_CONTROL_ID, 32'd32);
        tick();
        drive_resp(1'b0, 8'h0, 32'd0);
        chk("both_cmd_valid", {63'b0, bus.write_command_out.valid}, 64'd1);
        chk("both_cmd_addr", bus.write_command_out.address, 64'h2080);
        chk("both_counter", {32'b0, bus.write_job_counter_done}, 64'd32);
        drive_beat(1'b1, 32'h0000_00C3);
        tick();
        drive_beat(1'b0, 32'h0);
        tick();
        chk("bp_cmd2_addr", bus.write_command_out.address, 64'h2100);
        chk("bp_cmd2_ready", {63'b0, bus.write_data_ready_out}, 64'd0);
        drive_resp(1'b1, DATA_WRITE_CONTROL_ID, 32'd32);
        tick();
        tick();
        drive_resp(1'b0, 8'h0, 32'd0);
        wait_done("bp_done");
        chk("bp_counter", {32'b0, bus.write_job_counter_done}, 64'd96);
        disable_job();

        // Reset in the middle of a three-command job
        set_wed(64'h3000, 32'd96);
        bus.enabled_in = 1'b1;
        wait_ready("rs_ready_wait");
        drive_beat(1'b1, 32'h0000_00D1);
        tick();
        drive_beat(1'b0, 32'h0);
        tick();
        chk("rs_cmd0_addr", bus.write_command_out.address, 64'h3000);
        drive_resp(1'b1, DATA_WRITE_CONTROL_ID, 32'd32);
        tick();
        drive_resp(1'b0, 8'h0, 32'd0);
        chk("rs_counter_pre", {32'b0, bus.write_job_counter_done}, 64'd32);
        rstn = 1'b0;
        #1;
        chk("rs_cmd_valid", {63'b0, bus.write_command_out.valid}, 64'd0);
        chk("rs_cmd_addr", bus.write_command_out.address, 64'h0);
        chk("rs_data0", {63'b0, bus.write_data_0_out.valid}, 64'd0);
        chk("rs_ready", {63'b0, bus.write_data_ready_out}, 64'd0);
        chk("rs_counter", {32'b0, bus.write_job_counter_done}, 64'd0);
        chk("rs_done", {63'b0, bus.write_job_done_out}, 64'd0);
        bus.enabled_in = 1'b0;
        tick();
        rstn = 1'b1;
        drive_resp(1'b1, DATA_WRITE_CONTROL_ID, 32'd32);
        tick();
        drive_resp(1'b0, 8'h0, 32'd0);
        tick();
        chk("rs_stale_resp", {32'b0, bus.write_job_counter_done}, 64'd0);
        chk("rs_idle_ready", {63'b0, bus.write_data_ready_out}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
